// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: load-use and multi-cycle RAW detection, EX forwarding select, per-register countdown scoreboard.
// Latency: stall/forward outputs are combinational; a scoreboard entry becomes visible the cycle after issue.
// Backpressure: stall freezes PC and IF/ID and bubbles ID/EX; HAZARD_WAW_CHECK_EN also stalls writes to a pending rd.
module hazard_scoreboard_unit #(
    parameter int NREG    = 32,
    parameter int MAX_LAT = 8,
    parameter int SCW     = 16,
    localparam int AW     = $clog2(NREG),
    localparam int LW     = $clog2(MAX_LAT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    // ID stage
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1_addr,
    input  logic [AW-1:0]   id_rs2_addr,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [AW-1:0]   id_rd_addr,
    input  logic            id_RegWrite,
    input  logic            id_mc_op,
    input  logic [LW-1:0]   id_mc_lat,
    input  logic            flush,
    // EX stage
    input  logic [AW-1:0]   ex_rd_addr,
    input  logic            ex_MemRead,
    input  logic [AW-1:0]   ex_rs1_addr,
    input  logic [AW-1:0]   ex_rs2_addr,
    // MEM / WB stages
    input  logic [AW-1:0]   mem_rd_addr,
    input  logic [AW-1:0]   wb_rd_addr,
    input  logic            mem_RegWrite,
    input  logic            wb_RegWrite,
    // Pipeline control
    output logic            PCWrite,
    output logic            IF_ID_Write,
    output logic            ID_EX_Bubble,
    output logic [1:0]      ForwardA,
    output logic [1:0]      ForwardB,
    output logic [NREG-1:0] mc_pending,
    output logic [SCW-1:0]  stall_cycles
);

    // Forwarding select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Scoreboard state: one countdown per architectural register
    logic [LW-1:0]  cnt_q [NREG];
    logic [LW-1:0]  cnt_d [NREG];
    logic [SCW-1:0] stall_cycles_q;
    logic [SCW-1:0] stall_cycles_d;

    // Decoded hazard terms
    logic           rs1_live;
    logic           rs2_live;
    logic           load_use;
    logic           raw_mc;
    logic           waw_mc;
    logic           stall;
    logic           issue;
    logic [LW-1:0]  lat_clamped;

    // Derive the pending vector from the countdowns; x0 never holds an entry
    always_comb begin
        mc_pending = '0;
        for (int r = 1; r < NREG; r++) begin
            mc_pending[r] = (cnt_q[r] != '0);
        end
    end

    // Source operands that actually matter for hazards (x0 is hardwired zero)
    always_comb begin
        rs1_live = id_rs1_used && (id_rs1_addr != '0);
        rs2_live = id_rs2_used && (id_rs2_addr != '0);
    end

    // Load-use: the load in EX produces a register the ID instruction reads
    always_comb begin
        load_use = 1'b0;
        if (ex_MemRead && (ex_rd_addr != '0)) begin
            load_use = (id_rs1_used && (ex_rd_addr == id_rs1_addr)) ||
                       (id_rs2_used && (ex_rd_addr == id_rs2_addr));
        end
    end

    // RAW against an outstanding multi-cycle result; a source is released the
    // cycle after its count reaches zero, when WB/regfile supplies the value
    always_comb begin
        raw_mc = id_valid &&
                 ((rs1_live && mc_pending[id_rs1_addr]) ||
                  (rs2_live && mc_pending[id_rs2_addr]));
    end

`ifdef HAZARD_WAW_CHECK_EN
    // Hold any writer of a register whose multi-cycle result is still in flight
    always_comb begin
        waw_mc = id_valid && id_RegWrite && (id_rd_addr != '0) &&
                 mc_pending[id_rd_addr];
    end
`else
    // Without the WAW check a new issue to a pending rd simply restarts its count
    always_comb begin
        waw_mc = 1'b0;
    end
`endif

    // Stall decision and pipeline control; flush squashes the ID instruction so
    // it neither stalls nor issues, while in-flight counts keep running
    always_comb begin
        stall        = id_valid && !flush && (load_use || raw_mc || waw_mc);
        PCWrite      = !stall;
        IF_ID_Write  = !stall;
        ID_EX_Bubble = stall;
        issue        = id_valid && !flush && !stall && id_RegWrite &&
                       id_mc_op && (id_rd_addr != '0);
    end

    // Clamp the requested latency into 1..MAX_LAT so an entry always lives at
    // least one cycle and never exceeds the configured maximum
    always_comb begin
        lat_clamped = id_mc_lat;
        if (id_mc_lat == '0) begin
            lat_clamped = LW'(1);
        end else if (id_mc_lat > LW'(MAX_LAT)) begin
            lat_clamped = LW'(MAX_LAT);
        end
    end

    // Countdown next state: a new issue overrides the decrement of that entry
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (issue && (id_rd_addr == AW'(r))) begin
                cnt_d[r] = lat_clamped;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LW'(1);
            end
        end
    end

    // Saturating count of stalled cycles
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != {SCW{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + SCW'(1);
        end
    end

    // Scoreboard and statistics registers; reset discards every pending entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

    // EX operand forwarding; the younger MEM result wins over WB
    always_comb begin
        ForwardA = FWD_RF;
        if (mem_RegWrite && (mem_rd_addr != '0) && (mem_rd_addr == ex_rs1_addr)) begin
            ForwardA = FWD_MEM;
        end else if (wb_RegWrite && (wb_rd_addr != '0) && (wb_rd_addr == ex_rs1_addr)) begin
            ForwardA = FWD_WB;
        end

        ForwardB = FWD_RF;
        if (mem_RegWrite && (mem_rd_addr != '0) && (mem_rd_addr == ex_rs2_addr)) begin
            ForwardB = FWD_MEM;
        end else if (wb_RegWrite && (wb_rd_addr != '0) && (wb_rd_addr == ex_rs2_addr)) begin
            ForwardB = FWD_WB;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with default parameters.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// WAW expectations follow whether HAZARD_WAW_CHECK_EN is defined for the build.
module tb_hazard_scoreboard_unit;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int LW   = 4;
    localparam int SCW  = 16;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic [AW-1:0]   id_rs1_addr, id_rs2_addr;
    logic            id_rs1_used, id_rs2_used;
    logic [AW-1:0]   id_rd_addr;
    logic            id_RegWrite, id_mc_op;
    logic [LW-1:0]   id_mc_lat;
    logic            flush;
    logic [AW-1:0]   ex_rd_addr;
    logic            ex_MemRead;
    logic [AW-1:0]   ex_rs1_addr, ex_rs2_addr;
    logic [AW-1:0]   mem_rd_addr, wb_rd_addr;
    logic            mem_RegWrite, wb_RegWrite;
    logic            PCWrite, IF_ID_Write, ID_EX_Bubble;
    logic [1:0]      ForwardA, ForwardB;
    logic [NREG-1:0] mc_pending;
    logic [SCW-1:0]  stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard_unit #(.NREG(NREG), .MAX_LAT(8), .SCW(SCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_addr(id_rd_addr),
        .id_RegWrite(id_RegWrite), .id_mc_op(id_mc_op), .id_mc_lat(id_mc_lat),
        .flush(flush), .ex_rd_addr(ex_rd_addr), .ex_MemRead(ex_MemRead),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
        .mem_RegWrite(mem_RegWrite), .wb_RegWrite(wb_RegWrite),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .mc_pending(mc_pending), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_rd_addr = 0;
        id_RegWrite = 0; id_mc_op = 0; id_mc_lat = 0; flush = 0;
        ex_rd_addr = 0; ex_MemRead = 0; ex_rs1_addr = 0; ex_rs2_addr = 0;
        mem_rd_addr = 0; wb_rd_addr = 0; mem_RegWrite = 0; wb_RegWrite = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // Drive a multi-cycle op into ID with no source reads
    task automatic drive_mc(input logic [AW-1:0] rd, input logic [LW-1:0] lat);
        id_valid = 1; id_RegWrite = 1; id_mc_op = 1;
        id_rd_addr = rd; id_mc_lat = lat;
        id_rs1_used = 0; id_rs2_used = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #2;
        n_checks++;
        if (mc_pending !== '0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", mc_pending); end
        n_checks++;
        if (stall_cycles !== '0) begin n_fail++; $display("FAIL reset_stalls: got %0d want 0", stall_cycles); end
        n_checks++;
        if ({PCWrite, IF_ID_Write, ID_EX_Bubble} !== 3'b110) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 110", {PCWrite, IF_ID_Write, ID_EX_Bubble});
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_load_use();
        do_reset();
        ex_MemRead = 1; ex_rd_addr = 5;
        id_valid = 1; id_rs1_addr = 5; id_rs1_used = 1;
        #1;
        n_checks++;
        if ({PCWrite, IF_ID_Write, ID_EX_Bubble} !== 3'b001) begin
            n_fail++; $display("FAIL load_use_ctrl: got %b want 001", {PCWrite, IF_ID_Write, ID_EX_Bubble});
        end
        @(negedge clk);
        ex_MemRead = 0; ex_rd_addr = 0;   // bubble now in EX
        #1;
        n_checks++;
        if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL load_use_release: got %b want 1", PCWrite); end
        n_checks++;
        if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL load_use_count: got %0d want 1", stall_cycles); end
        // Same register but source not read: no stall
        ex_MemRead = 1; ex_rd_addr = 5; id_rs1_used = 0;
        #1;
        n_checks++;
        if (PCWrite !== 1'b1 || ID_EX_Bubble !== 1'b0) begin
            n_fail++; $display("FAIL load_use_unused: got pc=%b bub=%b want 1/0", PCWrite, ID_EX_Bubble);
        end
        // Match on rs2
        id_rs2_addr = 5; id_rs2_used = 1;
        #1;
        n_checks++;
        if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL load_use_rs2: got %b want 0", PCWrite); end
        // Load to x0 never stalls
        ex_rd_addr = 0; id_rs2_addr = 0;
        #1;
        n_checks++;
        if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL load_use_x0: got %b want 1", PCWrite); end
        clear_inputs();
    endtask

    task automatic test_mc_raw();
        do_reset();
        drive_mc(7, 4);
        #1;
        n_checks++;
        if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL mc_issue_nostall: got %b want 1", PCWrite); end
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_rs1_addr = 7; id_rs1_used = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (PCWrite !== 1'b0 || mc_pending[7] !== 1'b1) begin
                n_fail++; $display("FAIL mc_raw_stall%0d: got pc=%b pend=%b want 0/1", k, PCWrite, mc_pending[7]);
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (mc_pending[7] !== 1'b0 || PCWrite !== 1'b1) begin
            n_fail++; $display("FAIL mc_raw_release: got pend=%b pc=%b want 0/1", mc_pending[7], PCWrite);
        end
        n_checks++;
        if (stall_cycles !== 16'd4) begin n_fail++; $display("FAIL mc_raw_count: got %0d want 4", stall_cycles); end
        clear_inputs();
    endtask

    task automatic test_lat_clamp();
        do_reset();
        drive_mc(3, 0);
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (mc_pending !== 32'h0000_0008) begin n_fail++; $display("FAIL lat0_pending: got %h want 00000008", mc_pending); end
        @(negedge clk);
        n_checks++;
        if (mc_pending[3] !== 1'b0) begin n_fail++; $display("FAIL lat0_expire: got %b want 0", mc_pending[3]); end
        drive_mc(3, 15);
        @(negedge clk);
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (mc_pending[3] !== 1'b1) begin n_fail++; $display("FAIL lat15_hold%0d: got %b want 1", k, mc_pending[3]); end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (mc_pending[3] !== 1'b0) begin n_fail++; $display("FAIL lat15_expire: got %b want 0", mc_pending[3]); end
        drive_mc(0, 4);
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (mc_pending !== '0) begin n_fail++; $display("FAIL x0_no_entry: got %h want 0", mc_pending); end
    endtask

    task automatic test_forward();
        clear_inputs();
        mem_rd_addr = 9; wb_rd_addr = 9; ex_rs1_addr = 9; ex_rs2_addr = 9;
        mem_RegWrite = 1; wb_RegWrite = 1;
        #1;
        n_checks++;
        if (ForwardA !== 2'b10 || ForwardB !== 2'b10) begin
            n_fail++; $display("FAIL fwd_mem: got A=%b B=%b want 10/10", ForwardA, ForwardB);
        end
        mem_RegWrite = 0;
        #1;
        n_checks++;
        if (ForwardA !== 2'b01 || ForwardB !== 2'b01) begin
            n_fail++; $display("FAIL fwd_wb: got A=%b B=%b want 01/01", ForwardA, ForwardB);
        end
        mem_RegWrite = 1; ex_rs2_addr = 12;
        #1;
        n_checks++;
        if (ForwardA !== 2'b10 || ForwardB !== 2'b00) begin
            n_fail++; $display("FAIL fwd_split: got A=%b B=%b want 10/00", ForwardA, ForwardB);
        end
        mem_rd_addr = 0; wb_rd_addr = 0; ex_rs1_addr = 0; ex_rs2_addr = 0;
        #1;
        n_checks++;
        if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
            n_fail++; $display("FAIL fwd_x0: got A=%b B=%b want 00/00", ForwardA, ForwardB);
        end
        clear_inputs();
    endtask

    task automatic test_waw();
        do_reset();
        drive_mc(4, 5);
        @(negedge clk);
        drive_mc(4, 3);
`ifdef HAZARD_WAW_CHECK_EN
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL waw_stall%0d: got %b want 0", k, PCWrite); end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (PCWrite !== 1'b1 || mc_pending[4] !== 1'b0) begin
            n_fail++; $display("FAIL waw_release: got pc=%b pend=%b want 1/0", PCWrite, mc_pending[4]);
        end
        n_checks++;
        if (stall_cycles !== 16'd5) begin n_fail++; $display("FAIL waw_count: got %0d want 5", stall_cycles); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (mc_pending[4] !== 1'b1) begin n_fail++; $display("FAIL waw_reissue: got %b want 1", mc_pending[4]); end
`else
        #1;
        n_checks++;
        if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL waw_nostall: got %b want 1", PCWrite); end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (mc_pending[4] !== 1'b1) begin n_fail++; $display("FAIL waw_reload_hold: got %b want 1", mc_pending[4]); end
        @(negedge clk);
        #1;
        n_checks++;
        if (mc_pending[4] !== 1'b0) begin n_fail++; $display("FAIL waw_reload_expire: got %b want 0", mc_pending[4]); end
        n_checks++;
        if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL waw_count: got %0d want 0", stall_cycles); end
`endif
        clear_inputs();
    endtask

    task automatic test_flush_reset();
        do_reset();
        drive_mc(6, 3);
        @(negedge clk);
        // Stalling reader of x6 that is also an mc op to x5, but flushed
        drive_mc(5, 4);
        id_rs1_addr = 6; id_rs1_used = 1; flush = 1;
        #1;
        n_checks++;
        if ({PCWrite, IF_ID_Write, ID_EX_Bubble} !== 3'b110) begin
            n_fail++; $display("FAIL flush_ctrl: got %b want 110", {PCWrite, IF_ID_Write, ID_EX_Bubble});
        end
        @(negedge clk);
        flush = 0;
        #1;
        n_checks++;
        if (mc_pending[5] !== 1'b0 || mc_pending[6] !== 1'b1) begin
            n_fail++; $display("FAIL flush_no_issue: got p5=%b p6=%b want 0/1", mc_pending[5], mc_pending[6]);
        end
        n_checks++;
        if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", stall_cycles); end
        n_checks++;
        if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL flush_then_stall: got %b want 0", PCWrite); end
        // Asynchronous reset mid-countdown
        #1;
        rst_n = 0;
        #1;
        n_checks++;
        if (mc_pending !== '0 || stall_cycles !== '0) begin
            n_fail++; $display("FAIL async_reset: got pend=%h stalls=%0d want 0/0", mc_pending, stall_cycles);
        end
        n_checks++;
        if (PCWrite !== 1'b1 || ID_EX_Bubble !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_ctrl: got pc=%b bub=%b want 1/0", PCWrite, ID_EX_Bubble);
        end
        @(negedge clk);
        rst_n = 1;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mc_raw();
        test_lat_clamp();
        test_forward();
        test_waw();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 SHALL have parameter NREG, default 32: architectural register count, power of two, 8..64; AW = log2(NREG).
REQ-002 SHALL have parameter MAX_LAT, default 8: maximum multi-cycle op latency, 2..15; LW = clog2(MAX_LAT+1).
REQ-003 SHALL have parameter SCW, default 16: stall-counter width.
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_addr, id_rs2_addr  in  AW  ID source registers.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd_addr  in  AW  ID destination.
- id_RegWrite  in  1  ID instruction writes rd.
- id_mc_op  in  1  ID instruction is multi-cycle (MUL/DIV).
- id_mc_lat  in  LW  latency of that op in cycles.
- flush  in  1  ID instruction squashed (branch taken).
- ex_rd_addr  in  AW  EX destination.
- ex_MemRead  in  1  EX is a load.
- ex_rs1_addr, ex_rs2_addr  in  AW  EX sources.
- mem_rd_addr, wb_rd_addr  in  AW  MEM/WB destinations.
- mem_RegWrite, wb_RegWrite  in  1  MEM/WB write enables.
- PCWrite, IF_ID_Write  out  1  1 = advance; 0 = freeze.
- ID_EX_Bubble  out  1  inject NOP into ID/EX.
- ForwardA, ForwardB  out  2  00 regfile, 10 from MEM, 01 from WB.
- mc_pending  out  NREG  bit r = register r awaits multi-cycle result.
- stall_cycles  out  SCW  saturating count of stalled cycles.

Function
REQ-005 SHALL keep a per-register LW-bit countdown cnt[r]; mc_pending[r] = (cnt[r] != 0); cnt[0] SHALL always be 0.
REQ-006 SHALL assert load_use when ex_MemRead, ex_rd_addr != 0, and ex_rd_addr equals a used ID source.
REQ-007 SHALL assert raw_mc when id_valid and any used ID source r != 0 has mc_pending[r].
REQ-008 SHALL define stall = id_valid & !flush & (load_use | raw_mc | waw_mc); waw_mc is 0 unless REQ-017 applies.
REQ-009 When stall: PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1; otherwise 1, 1, 0; all combinational from state and current inputs.
REQ-010 Issue = id_valid & !flush & !stall & id_RegWrite & id_mc_op & id_rd_addr != 0. On the clock edge it SHALL load cnt[id_rd_addr] with id_mc_lat clamped to 1..MAX_LAT (0 is taken as 1; values above MAX_LAT are taken as MAX_LAT).
REQ-011 Every nonzero cnt[r] not being loaded SHALL decrement by 1 per cycle. A load in the same cycle SHALL take priority over the decrement.
REQ-012 A source becomes unblocked in the cycle after its count reaches 0; the result is then taken from WB forwarding or the regfile.
REQ-013 flush SHALL suppress issue and stall for that cycle only; counters already in flight SHALL continue counting down.
REQ-014 ForwardA SHALL be 10 if mem_RegWrite & mem_rd_addr != 0 & mem_rd_addr == ex_rs1_addr; else 01 if the same test on WB matches; else 00. ForwardB SHALL use the same rule with ex_rs2_addr. MEM has priority over WB.
REQ-015 stall_cycles SHALL increment by 1 on each clock with stall = 1 and SHALL saturate at all-ones.

Reset
REQ-016 While rst_n = 0, asynchronously: all cnt = 0, mc_pending = 0, and stall_cycles = 0. Combinational outputs then reflect an empty scoreboard: with no load_use, PCWrite = 1, IF_ID_Write = 1, ID_EX_Bubble = 0. A reset asserted mid-countdown SHALL discard all pending entries.

Configuration
REQ-017 Macro HAZARD_WAW_CHECK_EN:
- Defined: waw_mc = id_valid & id_RegWrite & id_rd_addr != 0 & mc_pending[id_rd_addr], which stalls any write to a register that still has a pending multi-cycle result.
- Undefined: waw_mc = 0, and a new issue to a pending rd restarts its count per REQ-010.

Verification
REQ-018 LW x5 in EX, ID reads x5 with rs1_used = 1 -> one cycle of PCWrite = 0, Bubble = 1, stall_cycles = 1; same case with rs1_used = 0 -> no stall.
REQ-019 Issue MUL to x7 with lat = 4, next instruction reads x7 -> stall for exactly 4 cycles, mc_pending[7] falls after 4 edges, 5th cycle advances.
REQ-020 Issue to x3 with lat = 0 and lat = 15 (MAX_LAT = 8) -> pending for 1 and 8 cycles respectively; issue to x0 -> no entry.
REQ-021 mem_rd = wb_rd = ex_rs1 = x9, both write enables set -> ForwardA = 10; with mem_RegWrite = 0 -> 01; with rd = x0 -> 00.
REQ-022 MUL to x4 pending, then a second mc op to x4 -> with HAZARD_WAW_CHECK_EN: stall until cnt[4] = 0; without it: no stall and cnt[4] reloads.
REQ-023 Reset pulse with cnt[6] = 3, plus flush asserted with a stalling hazard -> all pending cleared at once; flush cycle shows PCWrite = 1 and no issue.
